// File: rtl/redmule_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port between the RedMulE streamers, with an
// in-order ID FIFO for response routing. Define REDMULE_ARB_BURST_LOCK_EN for burst locking.
module redmule_tcdm_arbiter #(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            wen_i,
  input  logic [N_REQ*ADDR_W-1:0]     add_i,
  input  logic [N_REQ*DATA_W-1:0]     data_i,
  input  logic [N_REQ*DATA_W/8-1:0]   be_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [N_REQ-1:0]            r_valid_o,
  output logic [DATA_W-1:0]           r_data_o,
  output logic                        tcdm_req_o,
  output logic                        tcdm_wen_o,
  output logic [ADDR_W-1:0]           tcdm_add_o,
  output logic [DATA_W-1:0]           tcdm_data_o,
  output logic [DATA_W/8-1:0]         tcdm_be_o,
  input  logic                        tcdm_gnt_i,
  input  logic                        tcdm_r_valid_i,
  input  logic [DATA_W-1:0]           tcdm_r_data_i,
  output logic                        busy_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PtrW = $clog2(MAX_OUTST);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BeW  = DATA_W / 8;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
    return (i == IdxW'(N_REQ - 1)) ? '0 : i + IdxW'(1);
  endfunction

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] cand, cand_nxt, scan_idx;
  logic            found;
  logic            full, xfer, pop;

  logic [IdxW-1:0] fifo_q [MAX_OUTST];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q;
  logic [IdxW-1:0] head;

  // First active requester at or after the pointer, wrapping at N_REQ.
  always_comb begin
    cand     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_i[scan_idx]) begin
        found = 1'b1;
        cand  = scan_idx;
      end
    end
  end

  assign cand_nxt = wrap_inc(cand);
  assign full     = (cnt_q == CntW'(MAX_OUTST));
  assign head     = fifo_q[rd_ptr_q];

  assign tcdm_req_o  = found & ~full;
  assign xfer        = tcdm_req_o & tcdm_gnt_i;
  assign pop         = tcdm_r_valid_i & (cnt_q != '0);
  assign tcdm_wen_o  = wen_i[cand];
  assign tcdm_add_o  = add_i[32'(cand) * ADDR_W +: ADDR_W];
  assign tcdm_data_o = data_i[32'(cand) * DATA_W +: DATA_W];
  assign tcdm_be_o   = be_i[32'(cand) * BeW +: BeW];
  assign r_data_o    = tcdm_r_data_i;
  assign busy_o      = busy_q;

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (xfer) gnt_o[cand] = 1'b1;
    if (pop)  r_valid_o[head] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef REDMULE_ARB_BURST_LOCK_EN
  logic       lock_q, lock_d;
  logic [2:0] burst_q, burst_d;

  // The pointer parks on the last granted requester; burst_q counts its transfers (1..7).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    burst_d  = burst_q;
    if (xfer) begin
      if (lock_q && (cand == rr_ptr_q)) begin
        if (burst_q == 3'd7) begin
          rr_ptr_d = cand_nxt;
          lock_d   = 1'b0;
          burst_d  = 3'd0;
        end else begin
          burst_d = burst_q + 3'd1;
        end
      end else begin
        rr_ptr_d = cand;
        lock_d   = 1'b1;
        burst_d  = 3'd1;
      end
    end else if (lock_q && (!req_i[rr_ptr_q] || full)) begin
      rr_ptr_d = wrap_inc(rr_ptr_q);
      lock_d   = 1'b0;
      burst_d  = 3'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      burst_q <= 3'd0;
    end else if (clear_i) begin
      lock_q  <= 1'b0;
      burst_q <= 3'd0;
    end else begin
      lock_q  <= lock_d;
      burst_q <= burst_d;
    end
  end
`else
  always_comb begin
    rr_ptr_d = xfer ? cand_nxt : rr_ptr_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else if (clear_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      if (xfer) begin
        fifo_q[wr_ptr_q] <= cand;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q    <= cnt_d;
      busy_q   <= (cnt_d != '0);
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a downstream protocol violation; it is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && tcdm_r_valid_i) begin
      assert (cnt_q != '0) else $error("tcdm_r_valid_i with no outstanding transaction");
    end
  end
`endif

endmodule
